// File: rtl/rf_bypass_sb_pkg.sv
// Shared register-file constants and select helpers used by decode, the hazard unit and the RF.
package rf_bypass_sb_pkg;
  localparam int RF_WIDTH = 16;
  localparam int RF_NREGS = 8;
  localparam int RF_SELW  = 3;
  localparam int R0_IDX   = 0;

  typedef logic [RF_SELW-1:0] regsel_t;

  // A select addresses a real register.
  function automatic logic sel_in_range(input int sel, input int nregs);
    return (sel < nregs);
  endfunction

  // A select addresses a register that can be written or become busy.
  function automatic logic sel_writable(input int sel, input int nregs, input int r0_zero);
    return (sel < nregs) && !((r0_zero == 1) && (sel == R0_IDX));
  endfunction
endpackage

// File: rtl/rf_bypass_sb_scoreboard.sv
// Per-register busy scoreboard for RAW stall detection; produces the read-port ready flags.
module rf_scoreboard
  import rf_bypass_sb_pkg::*;
#(
  parameter int NREGS   = RF_NREGS,
  parameter int SELW    = RF_SELW,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic [SELW-1:0] issueregsel,
  input  logic            write,
  input  logic [SELW-1:0] writeregsel,
  input  logic [SELW-1:0] read1regsel,
  input  logic [SELW-1:0] read2regsel,
  output logic            read1ready,
  output logic            read2ready
);
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic             issue_ok_s;
  logic             write_ok_s;

  assign issue_ok_s = issue && !rst && sel_writable(32'(issueregsel), NREGS, R0_ZERO);
  assign write_ok_s = write && !rst && sel_writable(32'(writeregsel), NREGS, R0_ZERO);

  function automatic logic port_ready(input logic [SELW-1:0] sel);
    logic rdy;
    if (!sel_in_range(32'(sel), NREGS)) begin
      rdy = 1'b1;
    end else if ((BYPASS == 1) && write_ok_s && (writeregsel == sel)) begin
      rdy = 1'b1;
    end else begin
      rdy = !busy_r[sel];
    end
    return rdy;
  endfunction

  // Next busy vector: a new producer (issue) outranks a completing writer.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      if (issue_ok_s && (issueregsel == SELW'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (write_ok_s && (writeregsel == SELW'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Busy register; reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign read1ready = port_ready(read1regsel);
  assign read2ready = port_ready(read2regsel);
endmodule

// File: rtl/rf_bypass_sb.sv
// Parametrised 2-read/1-write register file with optional write bypass, optional zero R0
// and a busy scoreboard for decode-stage RAW stalls.
module rf_bypass_sb
  import rf_bypass_sb_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREGS   = RF_NREGS,
  parameter int SELW    = RF_SELW,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             read1ready,
  output logic             read2ready,
  input  logic [SELW-1:0]  writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             issue,
  input  logic [SELW-1:0]  issueregsel,
  output logic             err
);
  logic [WIDTH-1:0] regs_r [NREGS];
  logic             write_ok_s;

  assign write_ok_s = write && !rst && sel_writable(32'(writeregsel), NREGS, R0_ZERO);

  function automatic logic [WIDTH-1:0] read_mux(input logic [SELW-1:0] sel);
    logic [WIDTH-1:0] d;
    if (!sel_in_range(32'(sel), NREGS)) begin
      d = '0;
    end else if ((R0_ZERO == 1) && (32'(sel) == R0_IDX)) begin
      d = '0;
    end else if ((BYPASS == 1) && write_ok_s && (writeregsel == sel)) begin
      d = writedata;
    end else begin
      d = regs_r[sel];
    end
    return d;
  endfunction

  // Storage array; out-of-range and R0 (when hard-wired) writes never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (write_ok_s) begin
      regs_r[writeregsel] <= writedata;
    end
  end

  assign read1data = read_mux(read1regsel);
  assign read2data = read_mux(read2regsel);

  assign err = !sel_in_range(32'(read1regsel), NREGS)
            || !sel_in_range(32'(read2regsel), NREGS)
            || (write && !sel_in_range(32'(writeregsel), NREGS))
            || (issue && !sel_in_range(32'(issueregsel), NREGS));

  rf_scoreboard #(
    .NREGS  (NREGS),
    .SELW   (SELW),
    .BYPASS (BYPASS),
    .R0_ZERO(R0_ZERO)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issueregsel(issueregsel),
    .write      (write),
    .writeregsel(writeregsel),
    .read1regsel(read1regsel),
    .read2regsel(read2regsel),
    .read1ready (read1ready),
    .read2ready (read2ready)
  );
endmodule

// File: tb/tb_rf_bypass_sb.sv
// Directed bench: default build (a), no-bypass build (b), NREGS=6 with zero R0 (c), shared stimulus.
module tb_rf_bypass_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1regsel, read2regsel, writeregsel, issueregsel;
  logic [15:0] writedata;
  logic        write, issue;

  logic [15:0] r1d_a, r2d_a, r1d_b, r2d_b, r1d_c, r2d_c;
  logic        r1r_a, r2r_a, r1r_b, r2r_b, r1r_c, r2r_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_c_data [6];
  logic        exp_c_rdy  [6];

  always #5 clk = ~clk;

  rf_bypass_sb #(.WIDTH(16), .NREGS(8), .SELW(3), .BYPASS(1), .R0_ZERO(0)) dut_a (
    .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .read1data(r1d_a), .read2data(r2d_a), .read1ready(r1r_a), .read2ready(r2r_a),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .issue(issue), .issueregsel(issueregsel), .err(err_a));

  rf_bypass_sb #(.WIDTH(16), .NREGS(8), .SELW(3), .BYPASS(0), .R0_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .read1data(r1d_b), .read2data(r2d_b), .read1ready(r1r_b), .read2ready(r2r_b),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .issue(issue), .issueregsel(issueregsel), .err(err_b));

  rf_bypass_sb #(.WIDTH(16), .NREGS(6), .SELW(3), .BYPASS(1), .R0_ZERO(1)) dut_c (
    .clk(clk), .rst(rst), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .read1data(r1d_c), .read2data(r2d_c), .read1ready(r1r_c), .read2ready(r2r_c),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .issue(issue), .issueregsel(issueregsel), .err(err_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen a further 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; issue = 1'b0; writeregsel = 3'd0; issueregsel = 3'd0; writedata = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; read1regsel = 3'd0; read2regsel = 3'd0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state on every register
    for (int i = 0; i < 8; i++) begin
      read1regsel = 3'(i); read2regsel = 3'(7 - i);
      #1;
      check_eq("rst_r1d", 32'(r1d_a), 32'h0);
      check_eq("rst_r2d", 32'(r2d_a), 32'h0);
      check_eq("rst_r1r", 32'(r1r_a), 32'h1);
      check_eq("rst_r2r", 32'(r2r_a), 32'h1);
      check_eq("rst_err", 32'(err_a), 32'h0);
      check_eq("rst_err_c", 32'(err_c), ((i >= 6) || (7 - i >= 6)) ? 32'h1 : 32'h0);
      tick();
    end

    // Write reg3 with same-cycle read on port 2
    read1regsel = 3'd0; read2regsel = 3'd3;
    write = 1'b1; writeregsel = 3'd3; writedata = 16'h00AB;
    #1;
    check_eq("byp_a", 32'(r2d_a), 32'h00AB);
    check_eq("nobyp_b", 32'(r2d_b), 32'h0000);
    check_eq("byp_c", 32'(r2d_c), 32'h00AB);
    tick();
    idle(); read1regsel = 3'd3;
    #1;
    check_eq("wr_a", 32'(r1d_a), 32'h00AB);
    check_eq("wr_b", 32'(r1d_b), 32'h00AB);

    // Issue reg5, then complete it
    issue = 1'b1; issueregsel = 3'd5; read1regsel = 3'd5;
    #1;
    check_eq("iss_same_rdy", 32'(r1r_a), 32'h1);
    tick();
    idle();
    #1;
    check_eq("busy_a", 32'(r1r_a), 32'h0);
    check_eq("busy_b", 32'(r1r_b), 32'h0);
    check_eq("busy_c", 32'(r1r_c), 32'h0);
    write = 1'b1; writeregsel = 3'd5; writedata = 16'h1234;
    #1;
    check_eq("wb_rdy_a", 32'(r1r_a), 32'h1);
    check_eq("wb_d_a", 32'(r1d_a), 32'h1234);
    check_eq("wb_rdy_b", 32'(r1r_b), 32'h0);
    check_eq("wb_d_b", 32'(r1d_b), 32'h0000);
    tick();
    idle();
    #1;
    check_eq("post_rdy_a", 32'(r1r_a), 32'h1);
    check_eq("post_d_a", 32'(r1d_a), 32'h1234);
    check_eq("post_rdy_b", 32'(r1r_b), 32'h1);
    check_eq("post_d_b", 32'(r1d_b), 32'h1234);

    // Simultaneous issue and write to reg2: busy ends set
    issue = 1'b1; issueregsel = 3'd2; write = 1'b1; writeregsel = 3'd2; writedata = 16'h5A5A;
    tick();
    idle(); read2regsel = 3'd2;
    #1;
    check_eq("iw_rdy", 32'(r2r_a), 32'h0);
    check_eq("iw_d", 32'(r2d_a), 32'h5A5A);
    check_eq("iw_rdy_c", 32'(r2r_c), 32'h0);

    // R0 handling: zero-R0 build ignores the write and the issue
    issue = 1'b1; issueregsel = 3'd0; write = 1'b1; writeregsel = 3'd0; writedata = 16'hFFFF;
    read1regsel = 3'd0;
    #1;
    check_eq("r0_d_c", 32'(r1d_c), 32'h0);
    check_eq("r0_rdy_c", 32'(r1r_c), 32'h1);
    check_eq("r0_byp_a", 32'(r1d_a), 32'hFFFF);
    tick();
    idle();
    #1;
    check_eq("r0_d_c2", 32'(r1d_c), 32'h0);
    check_eq("r0_rdy_c2", 32'(r1r_c), 32'h1);
    check_eq("r0_d_a2", 32'(r1d_a), 32'hFFFF);
    check_eq("r0_rdy_a2", 32'(r1r_a), 32'h0);

    // Out-of-range select on the 6-register build
    read1regsel = 3'd7; read2regsel = 3'd3;
    #1;
    check_eq("oor_err_c", 32'(err_c), 32'h1);
    check_eq("oor_d_c", 32'(r1d_c), 32'h0);
    check_eq("oor_rdy_c", 32'(r1r_c), 32'h1);
    check_eq("oor_err_a", 32'(err_a), 32'h0);
    read1regsel = 3'd3; read2regsel = 3'd1;
    write = 1'b1; writeregsel = 3'd7; writedata = 16'hBEEF;
    #1;
    check_eq("oor_wr_err_c", 32'(err_c), 32'h1);
    check_eq("oor_wr_err_a", 32'(err_a), 32'h0);
    tick();
    idle();
    exp_c_data[0] = 16'h0000; exp_c_data[1] = 16'h0000; exp_c_data[2] = 16'h5A5A;
    exp_c_data[3] = 16'h00AB; exp_c_data[4] = 16'h0000; exp_c_data[5] = 16'h1234;
    exp_c_rdy[0] = 1'b1; exp_c_rdy[1] = 1'b1; exp_c_rdy[2] = 1'b0;
    exp_c_rdy[3] = 1'b1; exp_c_rdy[4] = 1'b1; exp_c_rdy[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      read1regsel = 3'(i);
      #1;
      check_eq("keep_d_c", 32'(r1d_c), 32'(exp_c_data[i]));
      check_eq("keep_rdy_c", 32'(r1r_c), 32'(exp_c_rdy[i]));
    end
    read1regsel = 3'd7;
    #1;
    check_eq("r7_a", 32'(r1d_a), 32'hBEEF);

    // Reset mid-operation drops busy bits and the write presented with it
    tick();
    issue = 1'b1; issueregsel = 3'd1;
    tick();
    issueregsel = 3'd4;
    tick();
    idle(); read1regsel = 3'd1; read2regsel = 3'd4;
    #1;
    check_eq("pre_rst_r1r", 32'(r1r_a), 32'h0);
    check_eq("pre_rst_r2r", 32'(r2r_a), 32'h0);
    rst = 1'b1; write = 1'b1; writeregsel = 3'd1; writedata = 16'h7777;
    tick();
    rst = 1'b0; idle();
    #1;
    check_eq("mid_r1d", 32'(r1d_a), 32'h0);
    check_eq("mid_r2d", 32'(r2d_a), 32'h0);
    check_eq("mid_r1r", 32'(r1r_a), 32'h1);
    check_eq("mid_r2r", 32'(r2r_a), 32'h1);
    check_eq("mid_r1d_b", 32'(r1d_b), 32'h0);
    check_eq("mid_r1r_b", 32'(r1r_b), 32'h1);
    read1regsel = 3'd2;
    #1;
    check_eq("mid_r2_d", 32'(r1d_a), 32'h0);
    check_eq("mid_r2_rdy", 32'(r1r_a), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_bypass_sb.md
Name: rf_bypass_sb

Overview:
- Parametrised successor to the 8x16 two-read/one-write register file, sized for the pipelined datapath.
- Adds configurable width and depth, optional write-to-read bypass, optional hard-wired zero register, and a per-register busy scoreboard that decode uses for RAW stall detection.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers; need not be a power of two.
- SELW, 3, register-select width; must satisfy 2**SELW >= NREGS.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only.
- R0_ZERO, 0, 1 = register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- read1regsel  in  SELW  read port 1 select.
- read2regsel  in  SELW  read port 2 select.
- read1data  out  WIDTH  read port 1 data, combinational.
- read2data  out  WIDTH  read port 2 data, combinational.
- read1ready  out  1  read port 1 operand is valid this cycle.
- read2ready  out  1  read port 2 operand is valid this cycle.
- writeregsel  in  SELW  write select.
- writedata  in  WIDTH  write data.
- write  in  1  write enable.
- issue  in  1  an instruction targeting issueregsel is issued this cycle.
- issueregsel  in  SELW  destination register of the issued instruction.
- err  out  1  any active select is >= NREGS, combinational.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a posedge, all registers go to 0 and all busy bits clear; write and issue are ignored in that cycle.
- Reset values: data outputs follow the reset register contents (0). readNready = 1, err = 0 when selects are in range.
- Write: if write=1 and writeregsel < NREGS (and not reg 0 when R0_ZERO=1), reg[writeregsel] <= writedata at the posedge. Latency: visible from storage the next cycle.
- Read: readNdata = reg[readNregsel], combinational.
  - If BYPASS=1, write=1 and writeregsel==readNregsel (valid, writable), readNdata = writedata in the same cycle.
  - An out-of-range select reads 0.
  - With R0_ZERO=1, a select of 0 reads 0.
- Scoreboard, one busy bit per register:
  - issue=1 with a valid, writable issueregsel sets busy at the posedge.
  - write=1 with a valid, writable writeregsel clears busy at the posedge.
  - Issue and write to the same register in the same cycle: busy ends SET, because the new producer wins.
  - Issue to a register that is already busy (WAW) keeps busy set; no error.
  - A write to a non-busy register is legal and stores normally.
- Ready: readNready = !busy[readNregsel], or 1 if BYPASS=1 and a write to that register occurs this cycle.
  - Out-of-range select: ready = 1, data 0, err = 1.
- err: asserted when any of read1regsel, read2regsel, or (writeregsel while write=1), or (issueregsel while issue=1) is >= NREGS. Out-of-range write and issue have no effect on state.
- Reset mid-operation: all pending busy bits are dropped; any write presented in the reset cycle is lost.

Decomposition:
- Shared package: default WIDTH and NREGS constants, a reg-select typedef of SELW bits, and the R0 index constant, all shared with decode and the hazard unit.
- One natural sub-module: rf_scoreboard, holding the busy vector with its set/clear priority logic and producing the ready flags.
- The storage array and bypass muxes stay in the top level.

Test Plan:
- Reset: hold rst 2 cycles, then read regs 0..7 -> all data 0, both ready=1, err=0.
- Write then read: write reg3=0x00AB; next cycle read1regsel=3 -> 0x00AB. With BYPASS=1 in the write cycle, read2regsel=3 -> 0x00AB same cycle; with BYPASS=0 -> 0x0000.
- Scoreboard:
  - Issue reg5 -> next cycle read1regsel=5 gives read1ready=0.
  - Write reg5=0x1234 -> same cycle read1ready=1 (BYPASS=1) with data 0x1234; following cycle ready=1 from storage.
- Simultaneous issue and write of reg2: after the edge read2ready=0 and data = the written value.
- R0_ZERO=1: write reg0=0xFFFF and issue reg0 -> reads 0, ready=1. NREGS=6: read1regsel=7 -> err=1, data 0; write to 7 leaves all registers unchanged.
- Reset mid-op: busy on regs 1 and 4, assert rst one cycle -> regs 1 and 4 read 0 and ready=1.
